// File: rtl/temp_avg_ctrl.sv
// Temperature-averaging front end: sums a window of samples and hands the sum to the sequential divider.
// Optional macro TEMP_AVG_ROUND_EN adds WINDOW/2 to each window sum so the average rounds to nearest.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no window waiting, divider not in use
// ST_ISSUE | div_start high, holding dividend until the divider accepts
// ST_BUSY  | division in flight, waiting for div_ready to fall and rise
module temp_avg_ctrl #(
  parameter int WINDOW   = 8,
  parameter int SAMPLE_W = 6
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic [8:0]          div_dividend,
  output logic [8:0]          div_divider,
  output logic                div_start,
  input  logic                div_ready,
  input  logic [8:0]          div_quotient,
  output logic [SAMPLE_W-1:0] avg_out,
  output logic                avg_valid,
  output logic                overrun
);

  localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);
`ifdef TEMP_AVG_ROUND_EN
  localparam logic [8:0] ROUND_ADD = 9'(WINDOW / 2);
`else
  localparam logic [8:0] ROUND_ADD = 9'd0;
`endif

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;

  logic [8:0]          acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [8:0]          hold_q, hold_d;
  logic                pend_q, pend_d;
  logic [1:0]          state_q, state_d;
  logic                seen_low_q, seen_low_d;
  logic [8:0]          dividend_q, dividend_d;
  logic [SAMPLE_W-1:0] avg_out_q, avg_out_d;
  logic                avg_valid_q, avg_valid_d;
  logic                overrun_q, overrun_d;

  logic       accept;
  logic       done;
  logic [8:0] win_sum;
  logic       unused_quotient_bits;

  // Quotient always fits in SAMPLE_W bits given the WINDOW constraint.
  assign unused_quotient_bits = ^div_quotient[8:SAMPLE_W];

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    pend_d      = pend_q;
    state_d     = state_q;
    seen_low_d  = 1'b0;
    dividend_d  = dividend_q;
    avg_out_d   = avg_out_q;
    avg_valid_d = 1'b0;
    overrun_d   = overrun_q;

    accept  = (state_q == ST_ISSUE) && div_ready;
    done    = (state_q == ST_BUSY) && div_ready && seen_low_q;
    win_sum = acc_q + 9'(sample_in);

    if (accept) begin
      pend_d = 1'b0;
    end

    // A window completing on the accept edge takes the freed slot.
    if (sample_valid) begin
      if (cnt_q == CNT_LAST) begin
        acc_d = 9'd0;
        cnt_d = '0;
        if (!pend_q || accept) begin
          hold_d = win_sum + ROUND_ADD;
          pend_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        acc_d = win_sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (pend_d) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (accept) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        seen_low_d = seen_low_q || !div_ready;
        if (done) begin
          avg_out_d   = div_quotient[SAMPLE_W-1:0];
          avg_valid_d = 1'b1;
          state_d     = pend_d ? ST_ISSUE : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_ISSUE) begin
      dividend_d = hold_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      acc_q       <= 9'd0;
      cnt_q       <= '0;
      hold_q      <= 9'd0;
      pend_q      <= 1'b0;
      state_q     <= ST_IDLE;
      seen_low_q  <= 1'b0;
      dividend_q  <= 9'd0;
      avg_out_q   <= '0;
      avg_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      pend_q      <= pend_d;
      state_q     <= state_d;
      seen_low_q  <= seen_low_d;
      dividend_q  <= dividend_d;
      avg_out_q   <= avg_out_d;
      avg_valid_q <= avg_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign div_start    = (state_q == ST_ISSUE);
  assign div_dividend = dividend_q;
  assign div_divider  = 9'(WINDOW);
  assign avg_out      = avg_out_q;
  assign avg_valid    = avg_valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_temp_avg_ctrl.sv
// Bench for temp_avg_ctrl: bench-side divider plus a window-level reference model checked every cycle.
`timescale 1ns/1ps
module tb_temp_avg_ctrl;

  localparam int WINDOW   = 8;
  localparam int SAMPLE_W = 6;
`ifdef TEMP_AVG_ROUND_EN
  localparam int RND          = WINDOW / 2;
  localparam int EXP_RAMP_DIV = 40;
  localparam int EXP_RAMP_AVG = 5;
  localparam int EXP_MAX_DIV  = 508;
`else
  localparam int RND          = 0;
  localparam int EXP_RAMP_DIV = 36;
  localparam int EXP_RAMP_AVG = 4;
  localparam int EXP_MAX_DIV  = 504;
`endif

  logic                clk = 1'b0;
  logic                n_rst;
  logic [SAMPLE_W-1:0] sample_in;
  logic                sample_valid;
  logic [8:0]          div_dividend;
  logic [8:0]          div_divider;
  logic                div_start;
  logic                div_ready;
  logic [8:0]          div_quotient;
  logic [SAMPLE_W-1:0] avg_out;
  logic                avg_valid;
  logic                overrun;

  temp_avg_ctrl #(.WINDOW(WINDOW), .SAMPLE_W(SAMPLE_W)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .div_dividend (div_dividend),
    .div_divider  (div_divider),
    .div_start    (div_start),
    .div_ready    (div_ready),
    .div_quotient (div_quotient),
    .avg_out      (avg_out),
    .avg_valid    (avg_valid),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // Bench divider: no reset, busy for 9 cycles after accepting, can be held not-ready.
  int         dv_cnt = 0;
  logic [8:0] dv_quo = 9'd0;
  logic       dv_force_low = 1'b0;
  assign div_ready    = (dv_cnt == 0) && !dv_force_low;
  assign div_quotient = dv_quo;

  always @(posedge clk) begin
    if (div_start && div_ready) begin
      dv_cnt <= 9;
      dv_quo <= (div_divider != 9'd0) ? 9'(div_dividend / div_divider) : 9'h1ff;
    end else if (dv_cnt != 0) begin
      dv_cnt <= dv_cnt - 1;
    end
  end

  // Reference model: window sums, one pending slot, one division in flight.
  int m_acc, m_cnt, m_hold, m_inval, exp_avg;
  bit m_pend, m_inflight, m_ovr, exp_start, exp_valid;
  bit chk_en = 1'b0;
  int n_pass = 0;
  int n_total = 0;
  int n_valid = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic model_step();
    bit acc_ev, done_ev;
    if (!n_rst) begin
      m_acc = 0; m_cnt = 0; m_hold = 0; m_inval = 0; exp_avg = 0;
      m_pend = 0; m_inflight = 0; m_ovr = 0; exp_start = 0; exp_valid = 0;
      chk_en = 1'b1;
    end else begin
      acc_ev  = exp_start && div_ready;
      done_ev = m_inflight && div_ready;
      exp_valid = 0;
      if (done_ev) begin
        exp_valid  = 1;
        exp_avg    = (m_inval / WINDOW) % (1 << SAMPLE_W);
        m_inflight = 0;
      end
      if (acc_ev) begin
        m_inflight = 1;
        m_inval    = m_hold;
        m_pend     = 0;
      end
      if (sample_valid) begin
        if (m_cnt == WINDOW - 1) begin
          if (m_pend) m_ovr = 1;
          else begin
            m_hold = m_acc + int'(sample_in) + RND;
            m_pend = 1;
          end
          m_acc = 0;
          m_cnt = 0;
        end else begin
          m_acc += int'(sample_in);
          m_cnt++;
        end
      end
      exp_start = m_pend && !m_inflight;
    end
  endtask

  task automatic compare_step();
    if (chk_en) begin
      check("div_start", div_start, exp_start);
      check("avg_valid", avg_valid, exp_valid);
      check("avg_out", avg_out, exp_avg);
      check("overrun", overrun, m_ovr);
      check("div_divider", div_divider, WINDOW);
      if (exp_start || m_inflight)
        check("div_dividend", div_dividend, exp_start ? m_hold : m_inval);
      if (avg_valid) n_valid++;
    end
  endtask

  always @(posedge clk) model_step();
  always @(negedge clk) compare_step();

  task automatic send(input int v);
    sample_in    = SAMPLE_W'(v);
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    sample_valid = 1'b0;
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic wait_avg(input int exp, input string nm);
    int k;
    k = 0;
    while (!avg_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (avg_valid) check(nm, avg_out, exp);
    else check({nm, "_timeout"}, avg_valid, 1);
    @(negedge clk);
  endtask

  initial begin
    int sum, v, v0, rate;
    sample_in = '0;
    sample_valid = 1'b0;
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_avg_out", avg_out, 0);
    check("rst_avg_valid", avg_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_div_start", div_start, 0);
    check("rst_div_dividend", div_dividend, 0);
    n_rst = 1'b1;
    @(negedge clk);

    for (int i = 1; i <= WINDOW; i++) send(i);
    check("ramp_start_next_cycle", div_start, 1);
    check("ramp_dividend", div_dividend, EXP_RAMP_DIV);
    check("ramp_divider", div_divider, 8);
    wait_avg(EXP_RAMP_AVG, "ramp_avg");

    for (int i = 0; i < WINDOW; i++) send(63);
    check("max_dividend", div_dividend, EXP_MAX_DIV);
    wait_avg(63, "max_avg");

    // Reset while the divider is busy; it must finish before the next start is taken.
    for (int i = 0; i < WINDOW; i++) send(5);
    repeat (4) @(negedge clk);
    dv_force_low = 1'b1;
    do_reset();
    for (int i = 0; i < WINDOW; i++) send(20);
    repeat (10) @(negedge clk);
    check("rst_busy_start_held", div_start, 1);
    dv_force_low = 1'b0;
    v0 = n_valid;
    wait_avg(20, "rst_busy_avg");
    repeat (15) @(negedge clk);
    check("rst_busy_single_pulse", n_valid - v0, 1);

    dv_force_low = 1'b1;
    sum = 0;
    for (int i = 0; i < WINDOW; i++) begin
      v = $urandom_range(0, 63);
      sum += v;
      send(v);
    end
    repeat (20) @(negedge clk);
    check("stall_start_held", div_start, 1);
    check("stall_dividend", div_dividend, sum + RND);
    dv_force_low = 1'b0;
    wait_avg((sum + RND) / WINDOW, "stall_avg");

    do_reset();
    for (int i = 0; i < 6 * WINDOW; i++) send($urandom_range(0, 63));
    repeat (40) @(negedge clk);
    check("b2b_overrun", overrun, 1);

    do_reset();
    v0 = n_valid;
    for (int i = 0; i < 2 * WINDOW; i++) send(10);
    repeat (50) @(negedge clk);
    check("cont_pulses", n_valid - v0, 2);
    check("cont_avg", avg_out, 10);
    check("cont_overrun", overrun, 0);

    do_reset();
    for (int blk = 0; blk < 6; blk++) begin
      rate = $urandom_range(10, 100);
      for (int i = 0; i < 150; i++) begin
        sample_in    = SAMPLE_W'($urandom_range(0, 63));
        sample_valid = ($urandom_range(0, 99) < rate);
        if ($urandom_range(0, 39) == 0) dv_force_low = ~dv_force_low;
        @(negedge clk);
      end
    end
    sample_valid = 1'b0;
    dv_force_low = 1'b0;
    repeat (60) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
